traffic_ctrl_fsm: RTL and testbench

- Phase sequencer for the highway/farm-road intersection.
- Consumes the latched farm and highway sensor requests from the sensor-latch stage (its FS_OUT and HS_OUT) and drives both light heads.
- Returns one-cycle FLEFT/HLEFT pulses to that stage to clear the serviced request.
- Highway green is the rest state. Farm green is granted on request, with minimum and maximum green times and yellow and all-red clearance intervals.

---
 rtl/traffic_ctrl_fsm.sv | 140 ++++++++++++++
 tb/tb_traffic_ctrl_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_fsm.sv
// rtl/traffic_ctrl_fsm.sv - highway/farm intersection phase sequencer with dwell timer and request-clear pulses
// Optional night-flash phase is compiled in with TRAFFIC_FLASH_EN.
module traffic_ctrl_fsm #(
   parameter int HG_MIN   = 16,
   parameter int FG_MIN   = 4,
   parameter int FG_MAX   = 12,
   parameter int YEL_T    = 3,
   parameter int ALLRED_T = 2,
   parameter int FLASH_T  = 8,
   parameter int CNT_W    = 8
) (
   input  logic       MCLK,
   input  logic       RESET,
   input  logic       FS_REQ,
   input  logic       HS_REQ,
   input  logic       FLASH,
   output logic [2:0] HL,
   output logic [2:0] FL,
   output logic       FLEFT,
   output logic       HLEFT
);

   typedef enum logic [2:0] {
      S_HG   = 3'd0,
      S_HY   = 3'd1,
      S_AR1  = 3'd2,
      S_FG   = 3'd3,
      S_FY   = 3'd4,
      S_AR2  = 3'd5,
      S_FLSH = 3'd6
   } state_t;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HG_MIN - 1);
   localparam logic [CNT_W-1:0] FGN_LAST = CNT_W'(FG_MIN - 1);
   localparam logic [CNT_W-1:0] FGX_LAST = CNT_W'(FG_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_T - 1);
   localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] TMAX     = '1;

   state_t           state;
   state_t           next;
   logic [CNT_W-1:0] timer;

`ifdef TRAFFIC_FLASH_EN
   localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_T - 1);
   logic [CNT_W-1:0] flash_cnt;
   logic             flash_on;

   // Toggle restarts "on" at every FLSH entry so the first half-period is always lit.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         flash_cnt <= '0;
         flash_on  <= 1'b1;
      end else if (state != S_FLSH) begin
         flash_cnt <= '0;
         flash_on  <= 1'b1;
      end else if (flash_cnt == FLASH_LAST) begin
         flash_cnt <= '0;
         flash_on  <= ~flash_on;
      end else begin
         flash_cnt <= flash_cnt + 1'b1;
      end
   end
`else
   logic unused_flash;
   assign unused_flash = FLASH;
`endif

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         state <= S_HG;
         timer <= '0;
         FLEFT <= 1'b0;
         HLEFT <= 1'b0;
      end else begin
         state <= next;
         if (next != state)
            timer <= '0;
         else if (timer != TMAX)
            timer <= timer + 1'b1;
         FLEFT <= (next == S_FG) && (state != S_FG);
         HLEFT <= (next == S_HG) && (state == S_AR2);
      end
   end

   always_comb begin
      next = state;
      case (state)
         S_HG: begin
`ifdef TRAFFIC_FLASH_EN
            if (timer >= HG_LAST && (FLASH || FS_REQ))
               next = S_HY;
`else
            if (timer >= HG_LAST && FS_REQ)
               next = S_HY;
`endif
         end
         S_HY: begin
            if (timer == YEL_LAST) begin
`ifdef TRAFFIC_FLASH_EN
               next = FLASH ? S_FLSH : S_AR1;
`else
               next = S_AR1;
`endif
            end
         end
         S_AR1: if (timer == AR_LAST) next = S_FG;
         S_FG:  if ((timer >= FGN_LAST && HS_REQ) || timer == FGX_LAST) next = S_FY;
         S_FY:  if (timer == YEL_LAST) next = S_AR2;
         S_AR2: if (timer == AR_LAST) next = S_HG;
`ifdef TRAFFIC_FLASH_EN
         S_FLSH: if (!FLASH) next = S_AR2;
`endif
         default: next = S_HG;
      endcase
   end

   always_comb begin
      HL = LAMP_R;
      FL = LAMP_R;
      case (state)
         S_HG: HL = LAMP_G;
         S_HY: HL = LAMP_Y;
         S_FG: FL = LAMP_G;
         S_FY: FL = LAMP_Y;
`ifdef TRAFFIC_FLASH_EN
         S_FLSH: begin
            HL = flash_on ? LAMP_Y : 3'b000;
            FL = flash_on ? LAMP_R : 3'b000;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_ctrl_fsm.sv
// tb/tb_traffic_ctrl_fsm.sv - scoreboard bench for traffic_ctrl_fsm phase timing and clear pulses
// Flash-phase case is compiled in with TRAFFIC_FLASH_EN.
module tb_traffic_ctrl_fsm;

   logic       MCLK = 1'b0;
   logic       RESET;
   logic       FS_REQ;
   logic       HS_REQ;
   logic       FLASH;
   logic [2:0] HL;
   logic [2:0] FL;
   logic       FLEFT;
   logic       HLEFT;

   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;

   typedef struct {
      int         cyc;
      logic [2:0] hl;
      logic [2:0] fl;
      logic       fleft;
      logic       hleft;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   traffic_ctrl_fsm dut (
      .MCLK   (MCLK),
      .RESET  (RESET),
      .FS_REQ (FS_REQ),
      .HS_REQ (HS_REQ),
      .FLASH  (FLASH),
      .HL     (HL),
      .FL     (FL),
      .FLEFT  (FLEFT),
      .HLEFT  (HLEFT)
   );

   always #5 MCLK = ~MCLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge MCLK) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check($sformatf("hl@%0d", mon_e.cyc), 32'(HL), 32'(mon_e.hl));
         check($sformatf("fl@%0d", mon_e.cyc), 32'(FL), 32'(mon_e.fl));
         check($sformatf("fleft@%0d", mon_e.cyc), 32'(FLEFT), 32'(mon_e.fleft));
         check($sformatf("hleft@%0d", mon_e.cyc), 32'(HLEFT), 32'(mon_e.hleft));
      end
   end

   // Cycle c counts from the first cycle after reset release; hy is the first HY cycle.
   function automatic exp_t model(input int c, input int hy, input int fg_len);
      exp_t e;
      int fg, fy, ar2, hg2;
      fg  = hy + 5;
      fy  = fg + fg_len;
      ar2 = fy + 3;
      hg2 = ar2 + 2;
      e.cyc = c;
      e.hl  = R;
      e.fl  = R;
      if (c < hy || c >= hg2)  e.hl = G;
      else if (c < hy + 3)     e.hl = Y;
      else if (c >= fg && c < fy) e.fl = G;
      else if (c >= fy && c < ar2) e.fl = Y;
      e.fleft = (c == fg);
      e.hleft = (c == hg2);
      return e;
   endfunction

   task automatic apply_reset(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         RESET  = 1'b1;
         FS_REQ = 1'b0;
         HS_REQ = 1'b0;
         FLASH  = 1'b0;
         e.cyc = -1; e.hl = G; e.fl = R; e.fleft = 1'b0; e.hleft = 1'b0;
         exp_q.push_back(e);
         @(posedge MCLK); #1;
      end
      RESET = 1'b0;
   endtask

   task automatic run_case(input int hy, input int fg_len, input int fs_on, input int fs_off,
                           input int hs_on, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         FS_REQ = (c >= fs_on && c < fs_off);
         HS_REQ = (c >= hs_on);
         exp_q.push_back(model(c, hy, fg_len));
         @(posedge MCLK); #1;
      end
   endtask

`ifdef TRAFFIC_FLASH_EN
   task automatic run_flash();
      exp_t e;
      for (int c = 0; c < 70; c++) begin
         FS_REQ = (c < 16);
         HS_REQ = 1'b0;
         FLASH  = (c < 60);
         e.cyc = c; e.hl = R; e.fl = R; e.fleft = 1'b0; e.hleft = (c == 63);
         if (c < 16 || c >= 63) e.hl = G;
         else if (c < 19)       e.hl = Y;
         else if (c <= 60) begin
            e.hl = ((((c - 19) / 8) % 2) == 0) ? Y : 3'b000;
            e.fl = ((((c - 19) / 8) % 2) == 0) ? R : 3'b000;
         end
         exp_q.push_back(e);
         @(posedge MCLK); #1;
      end
   endtask
`endif

   initial begin
      RESET  = 1'b1;
      FS_REQ = 1'b0;
      HS_REQ = 1'b0;
      FLASH  = 1'b0;
      @(posedge MCLK); #1;

      apply_reset(2);
      run_case(1000, 12, 1000, 1000, 1000, 100);

      apply_reset(1);
      run_case(16, 12, 0, 21, 1000, 60);

      apply_reset(1);
      run_case(16, 4, 0, 21, 22, 26);
      apply_reset(2);
      run_case(16, 12, 0, 1000, 1000, 20);

      apply_reset(1);
      run_case(31, 12, 30, 36, 1000, 56);

      apply_reset(1);
      run_case(16, 4, 0, 21, 0, 35);

`ifdef TRAFFIC_FLASH_EN
      apply_reset(1);
      run_flash();
`endif

      @(negedge MCLK); #1;
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
